// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_cmp_bit_cell.sv
// Single-bit comparator cell: greater, less and equal for one bit pair.
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic l,
  output logic e
);

  assign g = a & ~b;
  assign l = ~a & b;
  assign e = ~(a ^ b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator with registered GT/EQ/LT and done pulse.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic GT,
  output logic EQ,
  output logic LT
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gt_w_q, gt_w_d;
  logic             lt_w_q, lt_w_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             done_q, done_d;
  logic             cell_g, cell_l, cell_e;

  cmp_bit_cell u_cell (
    .a (a_bit),
    .b (b_bit),
    .g (cell_g),
    .l (cell_l),
    .e (cell_e)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gt_w_d  = gt_w_q;
    lt_w_d  = lt_w_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          gt_w_d  = 1'b0;
          lt_w_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // All bits consumed: publish the flags one cycle after the last bit.
          gt_d    = gt_w_q;
          lt_d    = lt_w_q;
          eq_d    = ~(gt_w_q | lt_w_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (bit_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          // MSB first: first difference sticks. LSB first: last difference wins.
          if (!cell_e && (MSB_FIRST == 0 || !(gt_w_q || lt_w_q))) begin
            gt_w_d = cell_g;
            lt_w_d = cell_l;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gt_w_q  <= 1'b0;
      lt_w_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gt_w_q  <= gt_w_d;
      lt_w_q  <= lt_w_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign GT   = gt_q;
  assign EQ   = eq_q;
  assign LT   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Drives one bit stream into an MSB-first and an LSB-first comparator and checks both.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst, start, bit_valid, a_bit, b_bit;
  logic busy_m, done_m, gt_m, eq_m, lt_m;
  logic busy_l, done_l, gt_l, eq_l, lt_l;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned last_done_cyc = 0;
  bit          pending_start = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy_m), .done(done_m), .GT(gt_m), .EQ(eq_m), .LT(lt_m)
  );

  serial_magnitude_comparator #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy_l), .done(done_l), .GT(gt_l), .EQ(eq_l), .LT(lt_l)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Expected {GT,EQ,LT} from plain integer comparison.
  function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a/b are streamed LSB first when lsb_order is set, otherwise MSB first.
  // Both DUTs see the same stream and interpret it in their own bit order.
  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input bit lsb_order,
                         input bit rand_gaps, input int stall_at, input int unsigned stall_len,
                         input int poke_at, input bit chain, input string tag);
    logic [7:0]  sa, sb, am, bm, al, bl;
    int unsigned n, gaps, total_gaps;
    for (int unsigned i = 0; i < 8; i++) begin
      sa[i] = lsb_order ? a[i] : a[7-i];
      sb[i] = lsb_order ? b[i] : b[7-i];
    end
    for (int unsigned i = 0; i < 8; i++) begin
      am[7-i] = sa[i]; bm[7-i] = sb[i];
      al[i]   = sa[i]; bl[i]   = sb[i];
    end
    if (!pending_start) start = 1'b1;
    bit_valid = $urandom_range(0, 1);
    a_bit = $urandom_range(0, 1);
    b_bit = $urandom_range(0, 1);
    tick();
    start = 1'b0;
    pending_start = 1'b0;
    n = 0;
    total_gaps = 0;
    check({tag, "_busy_m"}, busy_m, 1'b1);
    check({tag, "_busy_l"}, busy_l, 1'b1);
    check({tag, "_done_lo"}, {done_m, done_l}, 2'b00);
    for (int i = 0; i < 8; i++) begin
      gaps = (i == stall_at) ? stall_len : (rand_gaps ? $urandom_range(0, 2) : 0);
      repeat (gaps) begin
        bit_valid = 1'b0;
        a_bit = $urandom_range(0, 1);
        b_bit = $urandom_range(0, 1);
        tick();
        n++;
        total_gaps++;
      end
      bit_valid = 1'b1;
      a_bit = sa[i];
      b_bit = sb[i];
      if (i == poke_at) start = 1'b1;
      tick();
      n++;
      start = 1'b0;
      bit_valid = 1'b0;
    end
    bit_valid = $urandom_range(0, 1);
    while (!done_m && n < 9 + total_gaps + 5) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, {done_m, done_l}, 2'b11);
    check({tag, "_latency"}, n, 9 + total_gaps);
    check({tag, "_res_m"}, {gt_m, eq_m, lt_m}, ref_cmp(am, bm));
    check({tag, "_res_l"}, {gt_l, eq_l, lt_l}, ref_cmp(al, bl));
    check({tag, "_busy_off"}, {busy_m, busy_l}, 2'b00);
    last_done_cyc = cyc;
    if (chain) begin
      start = 1'b1;
      pending_start = 1'b1;
    end else begin
      bit_valid = 1'b0;
      tick();
      check({tag, "_pulse"}, {done_m, done_l}, 2'b00);
      check({tag, "_hold_m"}, {gt_m, eq_m, lt_m}, ref_cmp(am, bm));
      check({tag, "_hold_l"}, {gt_l, eq_l, lt_l}, ref_cmp(al, bl));
    end
  endtask

  initial begin
    int unsigned first_done;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    tick();
    start = 1'b1; bit_valid = 1'b1;
    tick();
    check("reset_m", {busy_m, done_m, gt_m, eq_m, lt_m}, 5'b0);
    check("reset_l", {busy_l, done_l, gt_l, eq_l, lt_l}, 5'b0);
    rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
    tick();
    check("idle_after_reset", {busy_m, busy_l}, 2'b00);

    run_cmp(8'hA5, 8'h5A, 1'b0, 1'b0, -1, 0, -1, 1'b0, "a5_5a");
    run_cmp(8'h01, 8'h80, 1'b1, 1'b0, -1, 0, -1, 1'b0, "lsb_01_80");
    run_cmp(8'h3C, 8'h3C, 1'b0, 1'b1, 4, 5, -1, 1'b0, "eq_msb");
    run_cmp(8'h3C, 8'h3C, 1'b1, 1'b1, 4, 5, -1, 1'b0, "eq_lsb");
    run_cmp(8'h10, 8'h20, 1'b0, 1'b0, -1, 0, 3, 1'b0, "poke");

    // Abort after 4 bits.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      a_bit = $urandom_range(0, 1);
      b_bit = $urandom_range(0, 1);
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_m", {busy_m, done_m, gt_m, eq_m, lt_m}, 5'b0);
    check("abort_l", {busy_l, done_l, gt_l, eq_l, lt_l}, 5'b0);
    tick();
    check("abort_nodone", {done_m, done_l, busy_m, busy_l}, 4'b0);
    run_cmp(8'hFF, 8'hFE, 1'b0, 1'b0, -1, 0, -1, 1'b0, "after_abort");

    run_cmp(8'h00, 8'h01, 1'b0, 1'b0, -1, 0, -1, 1'b1, "b2b_first");
    first_done = last_done_cyc;
    run_cmp(8'h02, 8'h02, 1'b0, 1'b0, -1, 0, -1, 1'b0, "b2b_second");
    check("b2b_period", last_done_cyc - first_done, 10);

    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      run_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'b1, -1, 0, -1, 1'($urandom_range(0, 1)), "rand");
    end
    if (pending_start) begin
      start = 1'b0;
      pending_start = 1'b0;
      repeat (12) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
